// File: rtl/cuenta_pkg.sv
// Shared types and constants for the ones/zeros counter.
// Optional early termination is selected by CUENTA_EARLY_EXIT_EN.
package cuenta_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CUENTA,
        FIN
    } state_t;

    localparam logic MODO_UNOS  = 1'b0;
    localparam logic MODO_CEROS = 1'b1;

endpackage

// File: rtl/cuenta_unos_n.sv
// Serial bit counter: counts ones (or zeros) of Valor, one bit per clock.
// Define CUENTA_EARLY_EXIT_EN to stop as soon as no counted bits remain.
module cuenta_unos_n
    import cuenta_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Valor,
    input  logic             start,
    input  logic             modo,
    output logic [CW-1:0]    Cuenta,
    output logic             fin,
    output logic             busy
);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    rem;
    logic             last;
    logic             accept;

    assign accept = start && (state != CUENTA);

`ifdef CUENTA_EARLY_EXIT_EN
    // Nothing left to count once the shifted register is empty.
    assign last = (rem == CW'(1)) || ((sr >> 1) == '0);
`else
    assign last = (rem == CW'(1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = CUENTA;
            CUENTA:  if (last)  state_nx = FIN;
            FIN:     state_nx = start ? CUENTA : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        fin  = 1'b0;
        unique case (state)
            CUENTA:  busy = 1'b1;
            FIN:     fin  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr     <= '0;
            rem    <= '0;
            Cuenta <= '0;
        end else if (accept) begin
            sr     <= (modo == MODO_CEROS) ? ~Valor : Valor;
            rem    <= CW'(WIDTH);
            Cuenta <= '0;
        end else if (state == CUENTA) begin
            sr     <= sr >> 1;
            rem    <= rem - CW'(1);
            Cuenta <= Cuenta + CW'(sr[0]);
        end
    end

endmodule

// File: tb/tb_cuenta_unos_n.sv
// Randomized and directed bench for cuenta_unos_n at WIDTH=8.
// Expected counts and latencies come from a popcount-style reference model.
module tb_cuenta_unos_n;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);
    localparam int BUDGET = 40;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] Valor;
    logic             start;
    logic             modo;
    logic [CW-1:0]    Cuenta;
    logic             fin;
    logic             busy;

    int errors = 0;
    int checks = 0;

    cuenta_unos_n #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Valor  (Valor),
        .start  (start),
        .modo   (modo),
        .Cuenta (Cuenta),
        .fin    (fin),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_count(logic [WIDTH-1:0] v, logic m);
        int c = 0;
        for (int i = 0; i < WIDTH; i++)
            if (v[i] != m) c++;
        return c;
    endfunction

    function automatic int ref_lat(logic [WIDTH-1:0] v, logic m);
`ifdef CUENTA_EARLY_EXIT_EN
        int hi = 0;
        for (int i = 0; i < WIDTH; i++)
            if (v[i] != m) hi = i;
        return hi + 1;
`else
        return WIDTH;
`endif
    endfunction

    // Present a start for one edge; returns at accept edge + 1.
    task automatic start_op(logic [WIDTH-1:0] v, logic m);
        Valor = v;
        modo  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until fin; lat = -1 on timeout.
    task automatic wait_fin(output int lat, output bit busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= BUDGET; k++) begin
            @(posedge clk);
            #1;
            if (fin) begin
                lat = k;
                if (busy) busy_ok = 1'b0;
                break;
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        int  lat;
        bit  bok;
        rst_n = 1'b0;
        start = 1'b1;
        Valor = 8'h3C;
        modo  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({Cuenta, fin, busy} !== {CW'(0), 2'b00}) begin
            errors++;
            $display("FAIL reset_state: Cuenta=%0d fin=%b busy=%b want 0 0 0",
                     Cuenta, fin, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy: got %b want 0", busy);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL first_accept: busy=%b want 1", busy);
        end
        wait_fin(lat, bok);
        checks++;
        if (lat != ref_lat(8'h3C, 1'b0) || Cuenta !== CW'(4)) begin
            errors++;
            $display("FAIL first_count: lat=%0d Cuenta=%0d want %0d 4",
                     lat, Cuenta, ref_lat(8'h3C, 1'b0));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed(string name, logic [WIDTH-1:0] v,
                                 logic m, int exp_c, int exp_l);
        int lat;
        bit bok;
        start_op(v, m);
        checks++;
        if (busy !== 1'b1 || Cuenta !== CW'(0)) begin
            errors++;
            $display("FAIL %s_accept: busy=%b Cuenta=%0d want 1 0",
                     name, busy, Cuenta);
        end
        wait_fin(lat, bok);
        checks++;
        if (lat != exp_l || !bok) begin
            errors++;
            $display("FAIL %s_latency: lat=%0d busy_ok=%b want %0d 1",
                     name, lat, bok, exp_l);
        end
        checks++;
        if (Cuenta !== CW'(exp_c)) begin
            errors++;
            $display("FAIL %s_count: Cuenta=%0d want %0d",
                     name, Cuenta, exp_c);
        end
        @(posedge clk);
        #1;
        checks++;
        if (fin !== 1'b0 || busy !== 1'b0 || Cuenta !== CW'(exp_c)) begin
            errors++;
            $display("FAIL %s_hold: fin=%b busy=%b Cuenta=%0d want 0 0 %0d",
                     name, fin, busy, Cuenta, exp_c);
        end
    endtask

    task automatic test_ones;
        test_directed("ones", 8'b1011_0101, 1'b0, 5, WIDTH);
    endtask

    task automatic test_zeros;
        test_directed("zeros", 8'b1011_0101, 1'b1, 3, WIDTH);
    endtask

    task automatic test_extremes;
`ifdef CUENTA_EARLY_EXIT_EN
        test_directed("all_zero", 8'h00, 1'b0, 0, 1);
`else
        test_directed("all_zero", 8'h00, 1'b0, 0, WIDTH);
`endif
        test_directed("all_ones", 8'hFF, 1'b0, WIDTH, WIDTH);
    endtask

    task automatic test_early_exit;
`ifdef CUENTA_EARLY_EXIT_EN
        test_directed("early", 8'b0000_0011, 1'b0, 2, 2);
`else
        test_directed("early", 8'b0000_0011, 1'b0, 2, WIDTH);
`endif
    endtask

    task automatic test_ignored_start;
        int lat;
        bit bok;
        start_op(8'b1011_0101, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        Valor = 8'hFF;
        modo  = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        Valor = 8'h00;
        wait_fin(lat, bok);
        checks++;
        if (lat != WIDTH - 3 || Cuenta !== CW'(5)) begin
            errors++;
            $display("FAIL ignored_start: lat=%0d Cuenta=%0d want %0d 5",
                     lat, Cuenta, WIDTH - 3);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        bit bok;
        // Still in FIN from the previous test: start held now.
        checks++;
        if (fin !== 1'b1) begin
            errors++;
            $display("FAIL b2b_in_fin: fin=%b want 1", fin);
        end
        start_op(8'h0F, 1'b0);
        checks++;
        if (busy !== 1'b1 || fin !== 1'b0 || Cuenta !== CW'(0)) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b fin=%b Cuenta=%0d want 1 0 0",
                     busy, fin, Cuenta);
        end
        wait_fin(lat, bok);
        checks++;
        if (lat != ref_lat(8'h0F, 1'b0) || Cuenta !== CW'(4) || !bok) begin
            errors++;
            $display("FAIL b2b_count: lat=%0d Cuenta=%0d want %0d 4",
                     lat, Cuenta, ref_lat(8'h0F, 1'b0));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mid_reset;
        bit seen;
        start_op(8'b1011_0101, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({Cuenta, fin, busy} !== {CW'(0), 2'b00}) begin
            errors++;
            $display("FAIL mid_reset: Cuenta=%0d fin=%b busy=%b want 0 0 0",
                     Cuenta, fin, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (fin || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_no_fin: activity=%b want 0", seen);
        end
    endtask

    task automatic test_random;
        int               lat;
        bit               bok;
        logic [WIDTH-1:0] v;
        logic             m;
        for (int n = 0; n < 40; n++) begin
            v = WIDTH'($urandom);
            m = 1'($urandom);
            start_op(v, m);
            wait_fin(lat, bok);
            checks++;
            if (lat != ref_lat(v, m) || Cuenta !== CW'(ref_count(v, m))
                || !bok) begin
                errors++;
                $display("FAIL random v=%h m=%b: lat=%0d Cuenta=%0d want %0d %0d",
                         v, m, lat, Cuenta, ref_lat(v, m), ref_count(v, m));
            end
            // Roughly half the runs chain straight from FIN.
            if ($urandom_range(1, 0) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        Valor = '0;
        start = 1'b0;
        modo  = 1'b0;
        rst_n = 1'b0;
        #1;
        test_reset;
        test_ones;
        test_zeros;
        test_extremes;
        test_early_exit;
        test_ignored_start;
        test_back_to_back;
        test_mid_reset;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cuenta_unos_n.md
CUENTA_UNOS_N -- requirements
Module: cuenta_unos_n

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The module SHALL have localparam CW, equal to $clog2(WIDTH+1), giving the count width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port Valor, input, WIDTH bits: operand, sampled only when a start is accepted.
REQ-006 The module SHALL have port start, input, 1 bit: request to begin a count.
REQ-007 The module SHALL have port modo, input, 1 bit: 0 counts ones, 1 counts zeros; sampled with Valor.
REQ-008 The module SHALL have port Cuenta, output, CW bits: running and final count.
REQ-009 The module SHALL have port fin, output, 1 bit: one-cycle done pulse.
REQ-010 The module SHALL have port busy, output, 1 bit: high while a count is in progress.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, CUENTA and FIN.
REQ-012 In IDLE or FIN, start=1 at a rising edge SHALL be accepted:
- load the shift register with Valor (bitwise inverted when modo=1);
- clear Cuenta to 0;
- load the remaining-bit counter with WIDTH;
- go to CUENTA.
REQ-013 In CUENTA, each edge SHALL add the shift-register LSB to Cuenta, shift right by one and decrement the remaining-bit counter.
REQ-014 The edge that processes the last bit SHALL move the FSM to FIN, so fin rises WIDTH edges after the accepting edge.
REQ-015 fin SHALL be high only in FIN, for exactly one cycle.
- FIN goes to IDLE when start=0.
- FIN goes to CUENTA when start=1 (back-to-back operation, no idle cycle).
REQ-016 busy SHALL be 1 exactly in CUENTA.
REQ-017 start asserted while in CUENTA SHALL be ignored; Valor and modo changes during CUENTA SHALL have no effect.
REQ-018 Cuenta SHALL hold its final value through FIN and IDLE until the next accepted start.
REQ-019 Cuenta SHALL never wrap: the maximum value is WIDTH, which CW always holds.

Reset
REQ-020 rst_n=0 SHALL force, asynchronously:
- state to IDLE;
- Cuenta to 0;
- fin and busy to 0;
- shift register and remaining-bit counter to 0.
REQ-021 Reset asserted in the middle of a count SHALL abort it with no fin pulse.
REQ-022 The first start SHALL be accepted only at the first rising edge after rst_n deasserts.

Configuration
REQ-023 The macro CUENTA_EARLY_EXIT_EN SHALL select the termination rule.
- Defined: in CUENTA, if the shift register after the current shift is all zero, the FSM SHALL go to FIN on that edge. Latency is then (index of highest counted bit + 1) edges, minimum 1.
- Undefined: latency SHALL always be exactly WIDTH edges.
REQ-024 The final Cuenta value SHALL be identical with and without CUENTA_EARLY_EXIT_EN.

Structure
REQ-025 Package cuenta_pkg SHALL hold:
- the state typedef (IDLE, CUENTA, FIN);
- the constants MODO_UNOS=1'b0 and MODO_CEROS=1'b1.
REQ-026 The block SHALL be a single module with no sub-modules; the shift register, counters and FSM live in one file.

Verification
REQ-027 The bench SHALL run at WIDTH=8 and cover at least these scenarios:
- Ones count: Valor=8'b1011_0101, modo=0, start for one cycle -> busy for 8 cycles, fin pulses 8 edges after the accepting edge, Cuenta=5.
- Zeros count: Valor=8'b1011_0101, modo=1 -> Cuenta=3 at fin.
- Extremes: Valor=8'hFF, modo=0 -> Cuenta=8 (no overflow); Valor=8'h00, modo=0 -> Cuenta=0, with fin after 8 edges, or after 1 edge with CUENTA_EARLY_EXIT_EN.
- Early exit: Valor=8'b0000_0011, modo=0 with CUENTA_EARLY_EXIT_EN -> fin 2 edges after the accepting edge, Cuenta=2; without the macro -> fin after 8 edges, Cuenta=2.
- Ignored start / back-to-back: start re-pulsed mid-count with Valor=8'hFF -> ignored, first result unchanged; start held high during FIN with Valor=8'h0F -> new count starts immediately, Cuenta=4 at the next fin.
- Mid-count reset: rst_n=0 on the 4th cycle of CUENTA -> Cuenta=0, busy=0 and fin=0 at once; no fin pulse follows.
